// File: rtl/ssp_port_arbiter.sv
// Two-client round-robin arbiter/sequencer for the SSP5 host port.
// Streams TX words in bounded bursts and returns single RX bytes.
module ssp_port_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       PCLK,
  input  logic       CLEAR_B,
  input  logic [1:0] WR_VALID,
  input  logic [7:0] WR_DATA0,
  input  logic [7:0] WR_DATA1,
  output logic [1:0] WR_READY,
  input  logic [1:0] RD_REQ,
  output logic [1:0] RD_VALID,
  output logic [7:0] RD_DATA,
  output logic       PSEL,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       SSPTXINTR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE
  } state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_q, rr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [1:0] rd_valid_q, rd_valid_d;

  logic [1:0] pend;
  logic       pick;
  logic       own_valid;
  logic       own_rd;
  logic       accept;
  logic [3:0] cnt_inc;

  assign pend      = RD_REQ | WR_VALID;
  assign pick      = pend[rr_q] ? rr_q : ~rr_q;
  assign own_valid = owner_q ? WR_VALID[1] : WR_VALID[0];
  assign own_rd    = owner_q ? RD_REQ[1] : RD_REQ[0];
  assign cnt_inc   = cnt_q + 4'd1;
  // a stalled word is simply not accepted; the owner keeps it presented
  assign accept    = (state_q == S_WRITE) & own_valid & ~SSPTXINTR;

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      cnt_q      <= 4'd0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if (|pend) begin
          owner_d = pick;
          cnt_d   = 4'd0;
          state_d = RD_REQ[pick] ? S_READ : S_WRITE;
        end
      end
      S_WRITE: begin
        if (accept) begin
          cnt_d = cnt_inc;
        end
        if (!own_valid || own_rd ||
            (accept && cnt_inc == 4'(MAX_BURST))) begin
          state_d = S_IDLE;
          rr_d    = ~owner_q;
        end
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        rd_data_d  = PRDATA;
        rd_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d    = S_IDLE;
        rr_d       = ~owner_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    WR_READY = 2'b00;
    PSEL     = 1'b0;
    PWRITE   = 1'b0;
    PWDATA   = 8'h00;
    unique case (state_q)
      S_WRITE: begin
        if (accept) begin
          WR_READY = owner_q ? 2'b10 : 2'b01;
          PSEL     = 1'b1;
          PWRITE   = 1'b1;
          PWDATA   = owner_q ? WR_DATA1 : WR_DATA0;
        end
      end
      S_READ: begin
        PSEL = 1'b1;
      end
      default: begin
        PSEL = 1'b0;
      end
    endcase
  end

  assign RD_VALID = rd_valid_q;
  assign RD_DATA  = rd_data_q;

endmodule

// File: tb/tb_ssp_port_arbiter.sv
// Scoreboard bench for ssp_port_arbiter: directed client traffic,
// expected SSP/RX events queued by stimulus, checked by a monitor.
module tb_ssp_port_arbiter;

  logic       PCLK = 1'b0;
  logic       CLEAR_B = 1'b1;
  logic       v0 = 1'b0;
  logic       v1 = 1'b0;
  logic [1:0] WR_VALID;
  logic [7:0] WR_DATA0 = 8'h00;
  logic [7:0] WR_DATA1 = 8'h00;
  logic [1:0] WR_READY;
  logic [1:0] RD_REQ = 2'b00;
  logic [1:0] RD_VALID;
  logic [7:0] RD_DATA;
  logic       PSEL;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA = 8'h00;
  logic       SSPTXINTR = 1'b0;

  assign WR_VALID = {v1, v0};

  ssp_port_arbiter #(.MAX_BURST(4)) dut (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B),
    .WR_VALID(WR_VALID), .WR_DATA0(WR_DATA0), .WR_DATA1(WR_DATA1),
    .WR_READY(WR_READY), .RD_REQ(RD_REQ), .RD_VALID(RD_VALID),
    .RD_DATA(RD_DATA), .PSEL(PSEL), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .SSPTXINTR(SSPTXINTR)
  );

  always #5 PCLK = ~PCLK;

  logic [7:0]  tx0[$];
  logic [7:0]  tx1[$];
  logic [11:0] exp_q[$];
  int          wr_t[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_seen = 0;
  int          cyc = 0;
  bit          hs0, hs1;

  function automatic logic [11:0] ev(input logic [1:0] k,
                                     input logic [1:0] c,
                                     input logic [7:0] d);
    return {k, c, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, expv);
    end
  endtask

  task automatic sb(input logic [11:0] act);
    logic [11:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_extra act=%h exp=none", act);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        errors++;
        $display("FAIL sb_event act=%h exp=%h", act, e);
      end
    end
  endtask

  task automatic wait_writes(input int n);
    int k;
    k = 0;
    while (wr_seen < n && k < 100) begin
      @(posedge PCLK);
      k++;
    end
    if (wr_seen < n) chk("wr_timeout", wr_seen, n);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {12'h0, PSEL, PWRITE, PWDATA, WR_READY, RD_VALID, RD_DATA},
        32'h0);
  endtask

  // client 0 / client 1 TX drivers: hold each word until accepted
  initial forever begin
    @(negedge PCLK);
    hs0 = v0 & WR_READY[0];
    @(posedge PCLK);
    if (hs0 && tx0.size() > 0) void'(tx0.pop_front());
    #1;
    v0 = (tx0.size() != 0);
    WR_DATA0 = v0 ? tx0[0] : 8'h00;
  end

  initial forever begin
    @(negedge PCLK);
    hs1 = v1 & WR_READY[1];
    @(posedge PCLK);
    if (hs1 && tx1.size() > 0) void'(tx1.pop_front());
    #1;
    v1 = (tx1.size() != 0);
    WR_DATA1 = v1 ? tx1[0] : 8'h00;
  end

  // monitor
  initial forever begin
    logic [1:0] cl;
    @(negedge PCLK);
    cyc++;
    if (CLEAR_B) begin
      if ((WR_READY & ~WR_VALID) != 2'b00 || WR_READY == 2'b11) begin
        chk("ready_inv", {30'h0, WR_READY}, {30'h0, WR_READY & WR_VALID});
      end
      if (PSEL) begin
        if (PWRITE) begin
          cl = (WR_READY == 2'b01) ? 2'd0 :
               (WR_READY == 2'b10) ? 2'd1 : 2'd3;
          wr_seen++;
          wr_t.push_back(cyc);
          sb(ev(2'd1, cl, PWDATA));
        end else begin
          sb(ev(2'd2, 2'd0, 8'h00));
        end
      end
      if (RD_VALID != 2'b00) begin
        cl = (RD_VALID == 2'b01) ? 2'd0 :
             (RD_VALID == 2'b10) ? 2'd1 : 2'd3;
        sb(ev(2'd3, cl, RD_DATA));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int stall_bad;
    int k;
    #2 CLEAR_B = 1'b0;
    #10 chk_zero("reset_state");
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    repeat (2) @(posedge PCLK);

    // contention, RR = 0 out of reset
    @(negedge PCLK);
    b = wr_seen;
    exp_q.push_back(ev(1, 0, 8'h94)); exp_q.push_back(ev(1, 0, 8'h0F));
    exp_q.push_back(ev(1, 0, 8'h51)); exp_q.push_back(ev(1, 0, 8'h24));
    exp_q.push_back(ev(1, 1, 8'hF3)); exp_q.push_back(ev(1, 1, 8'hB6));
    exp_q.push_back(ev(1, 1, 8'h84)); exp_q.push_back(ev(1, 1, 8'h11));
    exp_q.push_back(ev(1, 0, 8'h67)); exp_q.push_back(ev(1, 1, 8'h22));
    tx0 = '{8'h94, 8'h0F, 8'h51, 8'h24, 8'h67};
    tx1 = '{8'hF3, 8'hB6, 8'h84, 8'h11, 8'h22};
    wait_writes(b + 10);
    if (wr_t.size() >= b + 10) begin
      chk("burst_rate", wr_t[b+1] - wr_t[b], 1);
      chk("switch_gap0", wr_t[b+4] - wr_t[b+3], 2);
      chk("switch_gap1", wr_t[b+8] - wr_t[b+7], 2);
    end
    repeat (4) @(posedge PCLK);

    // single write
    @(negedge PCLK);
    b = wr_seen;
    exp_q.push_back(ev(1, 0, 8'h94));
    tx0.push_back(8'h94);
    wait_writes(b + 1);
    repeat (4) @(posedge PCLK);
    chk("single_count", wr_seen, b + 1);

    // TX full stall mid-burst, client 1 waiting
    @(negedge PCLK);
    b = wr_seen;
    exp_q.push_back(ev(1, 0, 8'h3C)); exp_q.push_back(ev(1, 0, 8'h5A));
    exp_q.push_back(ev(1, 0, 8'h51)); exp_q.push_back(ev(1, 0, 8'h7E));
    tx0 = '{8'h3C, 8'h5A, 8'h51, 8'h7E};
    wait_writes(b + 2);
    #1 SSPTXINTR = 1'b1;
    stall_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (i == 0) begin
        exp_q.push_back(ev(1, 1, 8'hE1));
        tx1.push_back(8'hE1);
      end
      if (PSEL || WR_READY != 2'b00) stall_bad++;
    end
    chk("stall_hold", stall_bad, 0);
    @(posedge PCLK);
    #1 SSPTXINTR = 1'b0;
    @(negedge PCLK);
    chk("stall_resume", {23'h0, PSEL, PWRITE, PWDATA}, {23'h0, 2'b11, 8'h51});
    wait_writes(b + 5);
    repeat (4) @(posedge PCLK);

    // read loopback, client 1
    @(posedge PCLK);
    #1;
    PRDATA = 8'hA5;
    RD_REQ[1] = 1'b1;
    exp_q.push_back(ev(2, 0, 8'h00));
    exp_q.push_back(ev(3, 1, 8'hA5));
    repeat (3) @(posedge PCLK);
    #2 chk("rd_latency", {22'h0, RD_VALID, RD_DATA}, {22'h0, 2'b10, 8'hA5});
    RD_REQ[1] = 1'b0;
    repeat (4) @(posedge PCLK);

    // read priority over own write, then client 1, then client 0
    @(negedge PCLK);
    b = wr_seen;
    PRDATA = 8'h3B;
    RD_REQ[0] = 1'b1;
    exp_q.push_back(ev(2, 0, 8'h00));
    exp_q.push_back(ev(3, 0, 8'h3B));
    exp_q.push_back(ev(1, 1, 8'hD2));
    exp_q.push_back(ev(1, 0, 8'hC3));
    tx0.push_back(8'hC3);
    tx1.push_back(8'hD2);
    k = 0;
    do begin
      @(posedge PCLK);
      #2;
      k++;
    end while (!RD_VALID[0] && k < 20);
    if (!RD_VALID[0]) chk("rd_timeout", {30'h0, RD_VALID}, 32'h1);
    RD_REQ[0] = 1'b0;
    wait_writes(b + 2);
    repeat (4) @(posedge PCLK);

    // async reset mid-burst; client 0 granted first after release
    @(negedge PCLK);
    b = wr_seen;
    exp_q.push_back(ev(1, 0, 8'hA1)); exp_q.push_back(ev(1, 0, 8'hA2));
    tx0 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    wait_writes(b + 2);
    #3 CLEAR_B = 1'b0;
    #1 chk_zero("rst_burst");
    @(negedge PCLK);
    exp_q.push_back(ev(1, 0, 8'hA3)); exp_q.push_back(ev(1, 0, 8'hA4));
    exp_q.push_back(ev(1, 1, 8'hB1));
    tx1.push_back(8'hB1);
    @(negedge PCLK);
    chk_zero("rst_hold");
    CLEAR_B = 1'b1;
    wait_writes(b + 5);
    repeat (4) @(posedge PCLK);

    // async reset during CAPTURE: no RD_VALID
    @(posedge PCLK);
    #1;
    PRDATA = 8'h77;
    RD_REQ[1] = 1'b1;
    exp_q.push_back(ev(2, 0, 8'h00));
    repeat (2) @(posedge PCLK);
    #3 CLEAR_B = 1'b0;
    #1 chk_zero("rst_capture");
    RD_REQ[1] = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    repeat (6) @(posedge PCLK);
    #1 chk_zero("post_capture");

    repeat (3) @(posedge PCLK);
    chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
